// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between instruction fetch (IF) and load/store (D)
// Ports:
//   clk, reset                               rising-edge clock, asynchronous active-low reset
//   ifReq, ifAdr                             fetch request (held until ifRdy) and its address
//   ifRdy, ifValid, ifData                   fetch accepted, one-cycle data pulse, fetched word
//   dReq, dWe, dAdr, dWdata, dMode           load/store request (held until dRdy) and attributes
//   dRdy, dValid, dData                      accepted, one-cycle done pulse, loaded word (0 for stores)
//   memEn, memWe, memAdr, memWdata, memMode  RAM strobe and access attributes
//   memRdata                                 RAM read data, valid MEM_LAT cycles after memEn
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [31:0] ifAdr,
    output logic        ifRdy,
    output logic        ifValid,
    output logic [31:0] ifData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAdr,
    input  logic [31:0] dWdata,
    input  logic [1:0]  dMode,
    output logic        dRdy,
    output logic        dValid,
    output logic [31:0] dData,
    output logic        memEn,
    output logic        memWe,
    output logic [31:0] memAdr,
    output logic [31:0] memWdata,
    output logic [1:0]  memMode,
    input  logic [31:0] memRdata
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, stateNext;
    logic          ownerD;
    logic          weReg;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic [31:0]   ifHold, dHold;
    logic          dWin, ifWin, done;

    always_comb begin
        // IF is forced through once D has won STARVE_MAX times while IF was waiting
        dWin = dReq && !(ifReq && starve == STARVE_TOP);
        ifWin = ifReq && !dWin;
        dRdy = reset && state == IDLE && dWin;
        ifRdy = reset && state == IDLE && ifWin;
        done = state == WAIT && cnt == '0;
        memEn = state == ISSUE;
        memWe = memEn && weReg;
        ifValid = done && !ownerD;
        dValid = done && ownerD;
        ifData = ifValid ? memRdata : ifHold;
        dData = dValid ? (weReg ? '0 : memRdata) : dHold;
        stateNext = state;
        case (state)
            IDLE:    stateNext = (ifRdy || dRdy) ? ISSUE : IDLE;
            ISSUE:   stateNext = WAIT;
            WAIT:    stateNext = (cnt == '0) ? IDLE : WAIT;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ownerD   <= 1'b0;
            weReg    <= 1'b0;
            cnt      <= '0;
            starve   <= '0;
            memAdr   <= '0;
            memWdata <= '0;
            memMode  <= '0;
            ifHold   <= '0;
            dHold    <= '0;
        end else begin
            state <= stateNext;
            if (state == ISSUE)
                cnt <= CNT_LOAD;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (dRdy) begin
                ownerD   <= 1'b1;
                weReg    <= dWe;
                memAdr   <= dAdr;
                memWdata <= dWdata;
                memMode  <= dMode;
            end else if (ifRdy) begin
                // fetches are always full-word reads
                ownerD   <= 1'b0;
                weReg    <= 1'b0;
                memAdr   <= ifAdr;
                memWdata <= '0;
                memMode  <= 2'd2;
            end
            if (state == IDLE)
                starve <= (!ifReq || ifRdy) ? '0 :
                          (dRdy && starve != STARVE_TOP) ? starve + 1'b1 : starve;
            if (ifValid)
                ifHold <= memRdata;
            if (dValid)
                dHold <= dData;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 1 and 3) against a transaction-level model and directed cases
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        reset [2];
    logic        ifReq [2];
    logic [31:0] ifAdr [2];
    logic        ifRdy [2];
    logic        ifValid [2];
    logic [31:0] ifData [2];
    logic        dReq [2];
    logic        dWe [2];
    logic [31:0] dAdr [2];
    logic [31:0] dWdata [2];
    logic [1:0]  dMode [2];
    logic        dRdy [2];
    logic        dValid [2];
    logic [31:0] dData [2];
    logic        memEn [2];
    logic        memWe [2];
    logic [31:0] memAdr [2];
    logic [31:0] memWdata [2];
    logic [1:0]  memMode [2];
    logic [31:0] memRdata [2];

    function automatic logic [31:0] initVal(logic [7:0] a);
        return (a == 8'h10) ? 32'hDEAD0001 : 32'hC0DE0000 + 32'(a) * 32'd257;
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
            .clk(clk), .reset(reset[g]),
            .ifReq(ifReq[g]), .ifAdr(ifAdr[g]), .ifRdy(ifRdy[g]), .ifValid(ifValid[g]), .ifData(ifData[g]),
            .dReq(dReq[g]), .dWe(dWe[g]), .dAdr(dAdr[g]), .dWdata(dWdata[g]), .dMode(dMode[g]),
            .dRdy(dRdy[g]), .dValid(dValid[g]), .dData(dData[g]),
            .memEn(memEn[g]), .memWe(memWe[g]), .memAdr(memAdr[g]), .memWdata(memWdata[g]),
            .memMode(memMode[g]), .memRdata(memRdata[g])
        );

        // RAM: writes on the strobe, read data appears exactly LAT cycles later, junk otherwise
        logic [31:0] ram [256];
        bit          wr [256];
        bit          pv [LAT];
        logic [7:0]  pa [LAT];
        bit   [31:0] junk;
        always @(posedge clk) begin
            if (memEn[g] && memWe[g]) begin
                ram[memAdr[g][7:0]] <= memWdata[g];
                wr[memAdr[g][7:0]] <= 1'b1;
            end
            pv[0] <= memEn[g];
            pa[0] <= memAdr[g][7:0];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            junk <= $urandom;
        end
        assign memRdata[g] = pv[LAT-1] ? (wr[pa[LAT-1]] ? ram[pa[LAT-1]] : initVal(pa[LAT-1])) : junk;

        // Model: one transaction at a time, k = cycles since acceptance
        bit          busy, own, hWe;
        int          k, starve;
        logic [31:0] hAdr, hWd, lastIf, lastD;
        logic [1:0]  hMode;
        logic [31:0] sh [256];
        bit          shw [256];
        always @(negedge clk) begin
            bit eIfRdy, eDRdy, eEn, eWe, eIfV, eDV, dW, iW;
            logic [31:0] eIfD, eDD, rd;
            eIfRdy = 0; eDRdy = 0; eEn = 0; eWe = 0; eIfV = 0; eDV = 0; dW = 0; iW = 0;
            if (!reset[g]) begin
                busy = 0; own = 0; hWe = 0; k = 0; starve = 0;
                hAdr = 0; hWd = 0; hMode = 0; lastIf = 0; lastD = 0;
            end else if (!busy) begin
                dW = dReq[g] && !(ifReq[g] && starve == 4);
                iW = ifReq[g] && !dW;
                eIfRdy = iW;
                eDRdy = dW;
            end else begin
                eEn = (k == 1);
                eWe = eEn && hWe;
                if (k == LAT + 1) begin
                    rd = shw[hAdr[7:0]] ? sh[hAdr[7:0]] : initVal(hAdr[7:0]);
                    eIfV = !own;
                    eDV = own;
                end
            end
            eIfD = eIfV ? rd : lastIf;
            eDD = eDV ? (hWe ? 32'h0 : rd) : lastD;
            chk("ifRdy", g, ifRdy[g], eIfRdy);
            chk("dRdy", g, dRdy[g], eDRdy);
            chk("memEn", g, memEn[g], eEn);
            chk("memWe", g, memWe[g], eWe);
            chk("memAdr", g, memAdr[g], hAdr);
            chk("memWdata", g, memWdata[g], hWd);
            chk("memMode", g, memMode[g], hMode);
            chk("ifValid", g, ifValid[g], eIfV);
            chk("dValid", g, dValid[g], eDV);
            chk("ifData", g, ifData[g], eIfD);
            chk("dData", g, dData[g], eDD);
            if (reset[g]) begin
                if (!busy) begin
                    if (dW) begin
                        busy = 1; k = 1; own = 1; hWe = dWe[g];
                        hAdr = dAdr[g]; hWd = dWdata[g]; hMode = dMode[g];
                        starve = ifReq[g] ? ((starve < 4) ? starve + 1 : 4) : 0;
                    end else if (iW) begin
                        busy = 1; k = 1; own = 0; hWe = 0;
                        hAdr = ifAdr[g]; hWd = 0; hMode = 2'd2; starve = 0;
                    end else
                        starve = 0;
                end else begin
                    if (k == 1 && hWe) begin
                        sh[hAdr[7:0]] = hWd;
                        shw[hAdr[7:0]] = 1;
                    end
                    if (k == LAT + 1) begin
                        busy = 0;
                        lastIf = eIfD;
                        lastD = eDD;
                    end else
                        k++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIf(input int g, input bit r, input logic [31:0] a);
        ifReq[g] = r;
        ifAdr[g] = a;
    endtask

    task automatic setD(input int g, input bit r, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] m);
        dReq[g] = r;
        dWe[g] = we;
        dAdr[g] = a;
        dWdata[g] = wd;
        dMode[g] = m;
    endtask

    // n = negedges waited before rdy, counting from the current cycle as 0
    task automatic waitRdy(input int g, input bit isD, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (isD ? dRdy[g] : ifRdy[g]) return;
            n++;
            if (n > 40) begin
                total++; bad++;
                $display("FAIL rdy_timeout dut%0d isD=%0d got=none want=rdy", g, isD);
                return;
            end
        end
    endtask

    // n = negedges up to and including the valid one
    task automatic waitValid(input int g, input bit isD, output int n, output logic [31:0] d);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (isD ? dValid[g] : ifValid[g]) begin
                d = isD ? dData[g] : ifData[g];
                return;
            end
            if (n > 40) begin
                total++; bad++;
                d = 'x;
                $display("FAIL valid_timeout dut%0d isD=%0d got=none want=valid", g, isD);
                return;
            end
        end
    endtask

    task automatic run(input int g, input int lat);
        int n;
        int got;
        logic [31:0] d;
        bit [5:0] seq;
        bit ifOn, dOn, ifGot, dGot;
        // reset with both requests high: nothing may be granted
        reset[g] = 0;
        setIf(g, 1, 32'h10);
        setD(g, 1, 1, 32'h20, 32'h55, 2'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ifRdy", g, ifRdy[g], 0);
        chk("rst_dRdy", g, dRdy[g], 0);
        chk("rst_memAdr", g, memAdr[g], 0);
        setIf(g, 0, 0);
        setD(g, 0, 0, 0, 0, 0);
        tick();
        reset[g] = 1;
        tick();
        // fetch alone
        setIf(g, 1, 32'h10);
        waitRdy(g, 0, n);
        chk("t1_rdyDelay", g, n, 0);
        tick();
        setIf(g, 0, 0);
        @(negedge clk);
        chk("t1_memEn", g, memEn[g], 1);
        chk("t1_memAdr", g, memAdr[g], 32'h10);
        waitValid(g, 0, n, d);
        chk("t1_lat", g, n, lat);
        chk("t1_data", g, d, 32'hDEAD0001);
        // load and fetch together: load first, fetch on the next idle cycle
        tick();
        setD(g, 1, 0, 32'h20, 0, 2'd2);
        setIf(g, 1, 32'h14);
        waitRdy(g, 1, n);
        chk("t2_dFirst", g, n, 0);
        chk("t2_ifWait", g, ifRdy[g], 0);
        tick();
        setD(g, 0, 0, 0, 0, 0);
        waitValid(g, 1, n, d);
        chk("t2_dLat", g, n, lat + 1);
        chk("t2_dData", g, d, 32'hC0DE2020);
        waitRdy(g, 0, n);
        chk("t2_ifNext", g, n, 0);
        tick();
        setIf(g, 0, 0);
        waitValid(g, 0, n, d);
        chk("t2_ifData", g, d, 32'hC0DE1414);
        // store, then load it back
        tick();
        setD(g, 1, 1, 32'h40, 32'h12345678, 2'd2);
        waitRdy(g, 1, n);
        tick();
        setD(g, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_memWe", g, memWe[g], 1);
        chk("t3_memMode", g, memMode[g], 2);
        chk("t3_memWdata", g, memWdata[g], 32'h12345678);
        waitValid(g, 1, n, d);
        chk("t3_storeData", g, d, 0);
        tick();
        setD(g, 1, 0, 32'h40, 0, 2'd2);
        waitRdy(g, 1, n);
        tick();
        setD(g, 0, 0, 0, 0, 0);
        waitValid(g, 1, n, d);
        chk("t3_loadBack", g, d, 32'h12345678);
        // fetch with a load arriving mid-access: no rdy until the fetch completes
        tick();
        setIf(g, 1, 32'h8);
        waitRdy(g, 0, n);
        tick();
        setIf(g, 0, 0);
        setD(g, 1, 0, 32'h8, 0, 2'd2);
        @(negedge clk);
        chk("t5_memEn", g, memEn[g], 1);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("t5_noRdy", g, dRdy[g] | ifRdy[g], 0);
            chk("t5_valid", g, ifValid[g], (i == lat) ? 1 : 0);
        end
        chk("t5_data", g, ifData[g], 32'hC0DE0808);
        waitRdy(g, 1, n);
        chk("t5_dNext", g, n, 0);
        tick();
        setD(g, 0, 0, 0, 0, 0);
        waitValid(g, 1, n, d);
        // starvation: D held against IF gives exactly four D grants, then IF
        tick();
        setD(g, 1, 0, 32'h24, 0, 2'd2);
        setIf(g, 1, 32'h30);
        seq = 0;
        got = 0;
        for (int c = 0; c < 200 && got < 6; c++) begin
            @(negedge clk);
            if (dRdy[g] || ifRdy[g]) begin
                seq = {seq[4:0], dRdy[g]};
                got++;
            end
            tick();
        end
        chk("t4_count", g, got, 6);
        chk("t4_order", g, 32'(seq), 32'b111101);
        setD(g, 0, 0, 0, 0, 0);
        setIf(g, 0, 0);
        repeat (lat + 3) tick();
        // reset while a load is waiting: dropped without a pulse
        setD(g, 1, 0, 32'h20, 0, 2'd2);
        waitRdy(g, 1, n);
        tick();
        setD(g, 0, 0, 0, 0, 0);
        tick();
        reset[g] = 0;
        @(negedge clk);
        chk("t6_dValid", g, dValid[g], 0);
        chk("t6_dData", g, dData[g], 0);
        chk("t6_ifData", g, ifData[g], 0);
        chk("t6_memAdr", g, memAdr[g], 0);
        tick();
        reset[g] = 1;
        setIf(g, 1, 32'h10);
        waitRdy(g, 0, n);
        chk("t6_rdyDelay", g, n, 0);
        tick();
        setIf(g, 0, 0);
        waitValid(g, 0, n, d);
        chk("t6_lat", g, n, lat + 1);
        chk("t6_data", g, d, 32'hDEAD0001);
        // random traffic; requests held until accepted, address may change while waiting
        ifOn = 0; dOn = 0; ifGot = 0; dGot = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            reset[g] = ($urandom_range(0, 149) != 0);
            if (ifGot) begin
                setIf(g, 0, 0);
                ifOn = 0;
            end
            if (dGot) begin
                setD(g, 0, 0, 0, 0, 0);
                dOn = 0;
            end
            if (!ifOn && $urandom_range(0, 2) == 0) begin
                setIf(g, 1, 32'($urandom_range(0, 63)) << 2);
                ifOn = 1;
            end else if (ifOn && $urandom_range(0, 7) == 0)
                ifAdr[g] = 32'($urandom_range(0, 63)) << 2;
            if (!dOn && $urandom_range(0, 1) == 0) begin
                setD(g, 1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                     $urandom, 2'($urandom_range(0, 3)));
                dOn = 1;
            end else if (dOn && $urandom_range(0, 7) == 0)
                dAdr[g] = 32'($urandom_range(0, 15)) << 2;
            @(negedge clk);
            ifGot = ifRdy[g];
            dGot = dRdy[g];
        end
        tick();
        reset[g] = 1;
        setIf(g, 0, 0);
        setD(g, 0, 0, 0, 0, 0);
        repeat (lat + 4) tick();
    endtask

    initial begin
        fork
            run(0, 1);
            run(1, 3);
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
